common_fifo_buffer: RTL

Parameterised synchronous FIFO with the same valid/ready handshake as `common_bypass_buffer`. It sits directly downstream of a `common_bypass_buffer`, takes that block's `next_o_*` outputs on its `prev_*` side, and absorbs bursts when the consumer stalls. It decouples producer and consumer by up to 2^BUFFER_DEPTH_LOG2 beats, and reports occupancy for flow-control and debug.

---
 rtl/common_fifo_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/common_fifo_buffer.sv
// Synchronous valid/ready FIFO of 2^BUFFER_DEPTH_LOG2 entries with occupancy count.
// Optional empty-FIFO bypass path enabled by COMMON_FIFO_BUFFER_BYPASS_EN.
module common_fifo_buffer #(
  parameter int unsigned BUFFER_WIDTH      = 32,
  parameter int unsigned BUFFER_DEPTH_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [BUFFER_WIDTH-1:0]      prev_i_data,
  input  logic                         prev_i_valid,
  output logic                         prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]      next_o_data,
  output logic                         next_o_valid,
  input  logic                         next_i_ready,
  output logic [BUFFER_DEPTH_LOG2:0]   next_o_count
);

  localparam int unsigned DEPTH = 1 << BUFFER_DEPTH_LOG2;
  localparam int unsigned CW    = BUFFER_DEPTH_LOG2 + 1;
  localparam int unsigned PW    = BUFFER_DEPTH_LOG2;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [BUFFER_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Ready comes from registered state only; a pop never frees a slot
  // for the same cycle.
  assign prev_o_ready = !full;
  assign next_o_count = count;

`ifdef COMMON_FIFO_BUFFER_BYPASS_EN
  // Empty FIFO forwards the upstream beat; if consumed right away it is
  // never stored, otherwise it lands in the array as a normal push.
  always_comb begin
    bypass       = empty && prev_i_valid && next_i_ready;
    next_o_valid = !empty;
    next_o_data  = mem[rptr];
    if (empty) begin
      next_o_valid = prev_i_valid;
      next_o_data  = prev_i_data;
    end
  end
`else
  // Head of queue read straight from the array; no prev->next path.
  always_comb begin
    bypass       = 1'b0;
    next_o_valid = !empty;
    next_o_data  = mem[rptr];
  end
`endif

  // Handshake qualifiers; a bypassed beat is neither pushed nor popped.
  always_comb begin
    push = prev_i_valid && prev_o_ready && !bypass;
    pop  = !empty && next_i_ready;
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= prev_i_data;
    end
  end

  // Pointers wrap naturally at the array size.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ONE_PTR;
      end
      if (pop) begin
        rptr <= rptr + ONE_PTR;
      end
    end
  end

  // Occupancy tracks push minus pop; both together leave it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        (push && !pop): count <= count + ONE_CNT;
        (pop && !push): count <= count - ONE_CNT;
        default:        count <= count;
      endcase
    end
  end

endmodule
